// File: rtl/ltc2308_sampler.sv
// LTC2308 frame controller: CONVST pulse, 12 SCK periods shifting config out on SDI
// and the conversion result in from SDO, then a one-cycle sample_valid strobe.
module ltc2308_sampler #(
  parameter int unsigned CLK_DIV     = 2,
  parameter int unsigned CONV_CYCLES = 80
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  channel,
  output logic [11:0] sample,
  output logic [2:0]  sample_channel,
  output logic        sample_valid,
  output logic        busy,
  output logic        ADC_CONVST,
  output logic        ADC_SCK,
  output logic        ADC_SDI,
  input  logic        ADC_SDO
);

  localparam int unsigned DATA_W = 12;
  localparam int unsigned CH_W   = 3;
  localparam int unsigned BIT_W  = 4;
  localparam int unsigned CONV_W = $clog2(CONV_CYCLES + 1);
  localparam int unsigned PH_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, CONV, XFER} state_t;

  state_t              state, state_n;
  logic [CONV_W-1:0]   conv_cnt, conv_cnt_n;
  logic [PH_W-1:0]     phase_cnt, phase_n;
  logic [BIT_W-1:0]    bit_cnt, bit_n;
  logic [DATA_W-1:0]   rx_shift, rx_n;
  logic [DATA_W-1:0]   tx_shift, tx_n;
  logic [CH_W-1:0]     cfg_ch, cfg_ch_n;
  logic [CH_W-1:0]     prev_ch, prev_ch_n;
  logic [DATA_W-1:0]   sample_n;
  logic [CH_W-1:0]     sample_channel_n;
  logic                sample_valid_n, busy_n, convst_n, sck_n, sdi_n;

  // Config word {S/D, O/S, S1, S0, UNI, SLP} left-aligned, zero padded for periods 7-12.
  function automatic logic [DATA_W-1:0] cfg_word(input logic [CH_W-1:0] ch);
    return {1'b1, ch[0], ch[2], ch[1], 1'b1, 1'b0, 6'b000000};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      conv_cnt       <= '0;
      phase_cnt      <= '0;
      bit_cnt        <= '0;
      rx_shift       <= '0;
      tx_shift       <= '0;
      cfg_ch         <= '0;
      prev_ch        <= '0;
      sample         <= '0;
      sample_channel <= '0;
      sample_valid   <= 1'b0;
      busy           <= 1'b0;
      ADC_CONVST     <= 1'b0;
      ADC_SCK        <= 1'b0;
      ADC_SDI        <= 1'b0;
    end else begin
      state          <= state_n;
      conv_cnt       <= conv_cnt_n;
      phase_cnt      <= phase_n;
      bit_cnt        <= bit_n;
      rx_shift       <= rx_n;
      tx_shift       <= tx_n;
      cfg_ch         <= cfg_ch_n;
      prev_ch        <= prev_ch_n;
      sample         <= sample_n;
      sample_channel <= sample_channel_n;
      sample_valid   <= sample_valid_n;
      busy           <= busy_n;
      ADC_CONVST     <= convst_n;
      ADC_SCK        <= sck_n;
      ADC_SDI        <= sdi_n;
    end
  end

  // Next-state and next-output logic; outputs are computed for the state being entered.
  always_comb begin
    state_n          = state;
    conv_cnt_n       = conv_cnt;
    phase_n          = phase_cnt;
    bit_n            = bit_cnt;
    rx_n             = rx_shift;
    tx_n             = tx_shift;
    cfg_ch_n         = cfg_ch;
    prev_ch_n        = prev_ch;
    sample_n         = sample;
    sample_channel_n = sample_channel;
    sample_valid_n   = 1'b0;
    convst_n         = 1'b0;
    sck_n            = ADC_SCK;
    sdi_n            = ADC_SDI;

    case (state)
      IDLE: begin
        sck_n = 1'b0;
        sdi_n = 1'b0;
        if (start) begin
          state_n    = CONV;
          cfg_ch_n   = channel;
          conv_cnt_n = '0;
          convst_n   = 1'b1;
        end
      end
      CONV: begin
        if (conv_cnt == CONV_W'(CONV_CYCLES - 1)) begin
          state_n = XFER;
          phase_n = '0;
          bit_n   = '0;
          sck_n   = 1'b0;
          tx_n    = cfg_word(cfg_ch);
          sdi_n   = tx_n[DATA_W-1];
        end else begin
          conv_cnt_n = conv_cnt + CONV_W'(1);
          convst_n   = 1'b1;
        end
      end
      XFER: begin
        if (phase_cnt == PH_W'(CLK_DIV - 1)) begin
          phase_n = '0;
          if (!ADC_SCK) begin
            // Last low-phase cycle: capture SDO just before SCK rises.
            rx_n  = {rx_shift[DATA_W-2:0], ADC_SDO};
            sck_n = 1'b1;
          end else if (bit_cnt == BIT_W'(DATA_W - 1)) begin
            state_n          = IDLE;
            sck_n            = 1'b0;
            sdi_n            = 1'b0;
            sample_n         = rx_shift;
            sample_channel_n = prev_ch;
            sample_valid_n   = 1'b1;
            prev_ch_n        = cfg_ch;
          end else begin
            bit_n = bit_cnt + BIT_W'(1);
            sck_n = 1'b0;
            tx_n  = {tx_shift[DATA_W-2:0], 1'b0};
            sdi_n = tx_n[DATA_W-1];
          end
        end else begin
          phase_n = phase_cnt + PH_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_ltc2308_sampler.sv
// Self-checking bench for ltc2308_sampler: LTC2308 pin model, cycle-offset reference
// model compared every cycle, plus directed scenarios with literal expectations.
module tb_ltc2308_sampler;

  localparam int CLK_DIV     = 2;
  localparam int CONV_CYCLES = 80;
  localparam int XFER_CYCLES = 24 * CLK_DIV;
  localparam int FRAME       = CONV_CYCLES + XFER_CYCLES + 1;

  logic        clk;
  logic        reset, start;
  logic [2:0]  channel;
  logic [11:0] sample;
  logic [2:0]  sample_channel;
  logic        sample_valid, busy;
  logic        ADC_CONVST, ADC_SCK, ADC_SDI, ADC_SDO;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  ltc2308_sampler #(.CLK_DIV(CLK_DIV), .CONV_CYCLES(CONV_CYCLES)) dut (
    .clk(clk), .reset(reset), .start(start), .channel(channel),
    .sample(sample), .sample_channel(sample_channel), .sample_valid(sample_valid),
    .busy(busy), .ADC_CONVST(ADC_CONVST), .ADC_SCK(ADC_SCK), .ADC_SDI(ADC_SDI),
    .ADC_SDO(ADC_SDO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ADC pin model: first bit valid after CONVST rises, next bit after each SCK fall.
  logic [11:0] adc_next, adc_word;
  logic [3:0]  adc_idx;
  assign ADC_SDO = adc_word[adc_idx];
  initial begin
    adc_word = '0;
    adc_idx  = 4'd11;
    forever begin
      @(posedge ADC_CONVST or negedge ADC_SCK);
      if (ADC_CONVST === 1'b1) begin
        adc_word = adc_next;
        adc_idx  = 4'd11;
      end else if (adc_idx != 4'd0) begin
        adc_idx = adc_idx - 4'd1;
      end
    end
  end

  // Event monitor: CONVST rises, SCK rises with SDI, valid strobes.
  int          rise_q[$];
  int          vcyc_q[$];
  logic [11:0] vdat_q[$];
  logic [2:0]  vch_q[$];
  int          sck_rises = 0;
  int          conv_high = 0;
  logic [11:0] sdi_log = '0;
  initial begin
    logic pc, ps, pv;
    pc = 1'b0; ps = 1'b0; pv = 1'b0;
    forever begin
      @(negedge clk);
      if (ADC_CONVST === 1'b1 && pc !== 1'b1) begin
        rise_q.push_back(cyc);
        sck_rises = 0;
        sdi_log   = '0;
        conv_high = 0;
      end
      if (ADC_CONVST === 1'b1) conv_high++;
      if (ADC_SCK === 1'b1 && ps !== 1'b1) begin
        sck_rises++;
        sdi_log = {sdi_log[10:0], ADC_SDI};
      end
      if (sample_valid === 1'b1) begin
        checks++;
        if (pv === 1'b1) begin
          failures++;
          $display("FAIL valid_adjacent cyc=%0d got=back-to-back strobes exp=isolated", cyc);
        end
        vcyc_q.push_back(cyc);
        vdat_q.push_back(sample);
        vch_q.push_back(sample_channel);
      end
      pc = ADC_CONVST; ps = ADC_SCK; pv = sample_valid;
    end
  end

  // Reference model: outputs as a function of the cycle offset from the accepted start.
  initial begin
    bit          armed, active;
    int          t0, k, j, p;
    logic [2:0]  cfg_m, prev_m, sch_m;
    logic [11:0] word_m, samp_m;
    logic [5:0]  cfg6;
    logic        e_valid, e_busy, e_conv, e_sck, e_sdi;
    logic [19:0] exp_v, got_v;
    armed = 0; active = 0; t0 = 0;
    cfg_m = '0; prev_m = '0; sch_m = '0; word_m = '0; samp_m = '0;
    forever begin
      @(negedge clk);
      e_valid = 0; e_busy = 0; e_conv = 0; e_sck = 0; e_sdi = 0;
      if (active) begin
        k    = cyc - t0;
        cfg6 = {1'b1, cfg_m[0], cfg_m[2], cfg_m[1], 1'b1, 1'b0};
        if (k >= 1 && k <= CONV_CYCLES) begin
          e_conv = 1; e_busy = 1;
        end else if (k > CONV_CYCLES && k <= CONV_CYCLES + XFER_CYCLES) begin
          e_busy = 1;
          j      = k - CONV_CYCLES - 1;
          e_sck  = ((j / CLK_DIV) % 2) == 1;
          p      = j / (2 * CLK_DIV);
          e_sdi  = (p < 6) ? cfg6[5 - p] : 1'b0;
        end else if (k == FRAME) begin
          e_valid = 1;
          samp_m  = word_m;
          sch_m   = prev_m;
          prev_m  = cfg_m;
          active  = 0;
        end
      end
      if (armed) begin
        exp_v = {samp_m, sch_m, e_valid, e_busy, e_conv, e_sck, e_sdi};
        got_v = {sample, sample_channel, sample_valid, busy, ADC_CONVST, ADC_SCK, ADC_SDI};
        checks++;
        if (got_v !== exp_v) begin
          failures++;
          $display("FAIL outputs cyc=%0d got=%05h exp=%05h (sample,ch,valid,busy,convst,sck,sdi)",
                   cyc, got_v, exp_v);
        end
      end
      if (reset === 1'b1) begin
        armed = 1; active = 0; prev_m = '0; samp_m = '0; sch_m = '0;
      end else if (armed && !active && start === 1'b1) begin
        active = 1; t0 = cyc; cfg_m = channel; word_m = adc_next;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic wait_valid(input int base, input int n, input int budget);
    for (int i = 0; i < budget && vcyc_q.size() < base + n; i++) tick();
    chk("valid_timeout", 32'(vcyc_q.size() >= base + n), 32'd1);
  endtask

  // Single start pulse; returns accept cycle and the valid-queue baseline.
  task automatic run_frame(input logic [2:0] ch, input logic [11:0] word,
                           output int t, output int vb);
    tick();
    channel = ch; adc_next = word; start = 1'b1;
    t = cyc; vb = vcyc_q.size();
    tick();
    start = 1'b0; channel = 3'd0;
    wait_valid(vb, 1, FRAME + 40);
  endtask

  initial begin
    int          t, vb, rb;
    logic [11:0] words [4];
    reset = 1'b1; start = 1'b0; channel = 3'd0; adc_next = '0;
    words[0] = 12'h000; words[1] = 12'hFFF; words[2] = 12'h800; words[3] = 12'h001;
    repeat (3) tick();
    reset = 1'b0;

    // Idle after reset: no activity.
    repeat (20) tick();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_sample", 32'(sample), 32'd0);
    chk("idle_convst_rises", 32'(rise_q.size()), 32'd0);
    chk("idle_sck_rises", 32'(sck_rises), 32'd0);

    // Basic frame, channel 5, word A5C.
    rb = rise_q.size();
    run_frame(3'd5, 12'hA5C, t, vb);
    repeat (5) tick();
    chk("f1_convst_rise", 32'(rise_q[rb]), 32'(t + 1));
    chk("f1_convst_len", 32'(conv_high), 32'd80);
    chk("f1_sck_rises", 32'(sck_rises), 32'd12);
    chk("f1_sdi_cfg", 32'(sdi_log[11:6]), 32'b111010);
    chk("f1_sdi_tail", 32'(sdi_log[5:0]), 32'd0);
    chk("f1_valid_count", 32'(vcyc_q.size()), 32'(vb + 1));
    chk("f1_valid_cyc", 32'(vcyc_q[vb]), 32'(t + 129));
    chk("f1_sample", 32'(vdat_q[vb]), 32'hA5C);
    chk("f1_channel", 32'(vch_q[vb]), 32'd0);

    // Channel pipelining.
    run_frame(3'd3, 12'h123, t, vb);
    chk("pipe1_ch", 32'(vch_q[vb]), 32'd5);
    chk("pipe1_data", 32'(vdat_q[vb]), 32'h123);
    run_frame(3'd6, 12'h456, t, vb);
    chk("pipe2_ch", 32'(vch_q[vb]), 32'd3);
    run_frame(3'd0, 12'h789, t, vb);
    chk("pipe3_ch", 32'(vch_q[vb]), 32'd6);
    chk("pipe3_data", 32'(vdat_q[vb]), 32'h789);

    // Back-to-back frames with start held high.
    tick();
    channel = 3'd2; adc_next = words[0]; start = 1'b1;
    t = cyc; rb = rise_q.size(); vb = vcyc_q.size();
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < FRAME + 20 && rise_q.size() <= rb + i; c++) tick();
      chk("b2b_rise_seen", 32'(rise_q.size() > rb + i), 32'd1);
      if (i < 3) adc_next = words[i + 1];
    end
    start = 1'b0;
    wait_valid(vb, 4, FRAME + 40);
    for (int i = 0; i < 4; i++) begin
      chk("b2b_rise_cyc", 32'(rise_q[rb + i]), 32'(t + 1 + FRAME * i));
      chk("b2b_valid_cyc", 32'(vcyc_q[vb + i]), 32'(t + FRAME * (i + 1)));
      chk("b2b_data", 32'(vdat_q[vb + i]), 32'(words[i]));
    end

    // Reset one cycle after the 5th SCK rise; aborted frame must not report.
    tick();
    channel = 3'd1; adc_next = 12'h3C3; start = 1'b1;
    rb = rise_q.size(); vb = vcyc_q.size();
    tick();
    start = 1'b0;
    for (int c = 0; c < 20 && rise_q.size() <= rb; c++) tick();
    for (int c = 0; c < FRAME && sck_rises < 5; c++) tick();
    chk("abort_sck5_seen", 32'(sck_rises), 32'd5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("abort_outputs_zero",
        32'({sample, sample_channel, sample_valid, busy, ADC_CONVST, ADC_SCK, ADC_SDI}), 32'd0);
    repeat (FRAME + 10) tick();
    chk("abort_no_valid", 32'(vcyc_q.size()), 32'(vb));
    run_frame(3'd4, 12'h5A5, t, vb);
    chk("post_rst_valid_cyc", 32'(vcyc_q[vb]), 32'(t + 129));
    chk("post_rst_data", 32'(vdat_q[vb]), 32'h5A5);
    chk("post_rst_ch", 32'(vch_q[vb]), 32'd0);
    chk("post_rst_sdi", 32'(sdi_log[11:6]), 32'b101010);

    // Starts during a busy frame are ignored; channel changes do not leak into SDI.
    tick();
    channel = 3'd7; adc_next = 12'hE17; start = 1'b1;
    t = cyc; vb = vcyc_q.size();
    tick();
    start = 1'b0; channel = 3'd3;
    while (cyc < t + 10) tick();
    start = 1'b1; channel = 3'd0;
    tick();
    start = 1'b0; channel = 3'd5;
    while (cyc < t + 100) tick();
    start = 1'b1; channel = 3'd2;
    tick();
    start = 1'b0;
    wait_valid(vb, 1, FRAME);
    repeat (20) tick();
    chk("ign_valid_count", 32'(vcyc_q.size()), 32'(vb + 1));
    chk("ign_valid_cyc", 32'(vcyc_q[vb]), 32'(t + 129));
    chk("ign_data", 32'(vdat_q[vb]), 32'hE17);
    chk("ign_ch", 32'(vch_q[vb]), 32'd4);
    chk("ign_sdi", 32'(sdi_log[11:6]), 32'b111110);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
